// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types and constants for the two-requester I2C master arbiter.
package i2c_master_arbiter_pkg;

    localparam int NUM_REQ = 2;
    localparam int WD_W    = 16;

    typedef enum logic [1:0] {
        stIdle    = 2'd0,
        stGrant0  = 2'd1,
        stGrant1  = 2'd2,
        stRelease = 2'd3
    } state_t;

endpackage

// File: rtl/i2c_master_arbiter_grant_watchdog.sv
// Idle-hold watchdog: loadable down-counter that saturates at zero.
module grant_watchdog
    import i2c_master_arbiter_pkg::*;
(
    input  logic            Clk_i,
    input  logic            Reset_n_i,
    input  logic            load_i,
    input  logic            en_i,
    input  logic [WD_W-1:0] preset_i,
    output logic            zero_o
);

    logic [WD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = preset_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master between two requesters,
// with a watchdog that revokes grants held idle for too long.
module i2c_master_arbiter
    import i2c_master_arbiter_pkg::*;
(
    input  logic            Clk_i,
    input  logic            Reset_n_i,
    input  logic            Req0_i,
    input  logic            Req1_i,
    output logic            Grant0_o,
    output logic            Grant1_o,
    input  logic            ReceiveSend_n0_i,
    input  logic [7:0]      ReadCount0_i,
    input  logic            StartProcess0_i,
    input  logic            FIFOReadNext0_i,
    input  logic            FIFOWrite0_i,
    input  logic [7:0]      Data0_i,
    output logic            Busy0_o,
    output logic            Error0_o,
    output logic [7:0]      Data0_o,
    input  logic            ReceiveSend_n1_i,
    input  logic [7:0]      ReadCount1_i,
    input  logic            StartProcess1_i,
    input  logic            FIFOReadNext1_i,
    input  logic            FIFOWrite1_i,
    input  logic [7:0]      Data1_i,
    output logic            Busy1_o,
    output logic            Error1_o,
    output logic [7:0]      Data1_o,
    output logic            I2C_ReceiveSend_n_o,
    output logic [7:0]      I2C_ReadCount_o,
    output logic            I2C_StartProcess_o,
    output logic            I2C_FIFOReadNext_o,
    output logic            I2C_FIFOWrite_o,
    output logic [7:0]      I2C_Data_o,
    input  logic            I2C_Busy_i,
    input  logic            I2C_Error_i,
    input  logic [7:0]      I2C_Data_i,
    input  logic [WD_W-1:0] ParamGrantTimeout_i,
    output logic            Timeout_o
);

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [NUM_REQ-1:0]   blocked_q, blocked_d;
    logic                 timeout_q, timeout_d;
    logic [NUM_REQ-1:0]   eff_req;
    logic                 in_grant, cur_idx, cur_req;
    logic                 wd_zero, wd_load, wd_en, expire;

    assign eff_req  = {Req1_i, Req0_i} & ~blocked_q;
    assign in_grant = (state_q == stGrant0) || (state_q == stGrant1);
    assign cur_idx  = (state_q == stGrant1);
    assign cur_req  = cur_idx ? Req1_i : Req0_i;
    assign expire   = in_grant && wd_zero && cur_req && !I2C_Busy_i &&
                      (ParamGrantTimeout_i != '0);

    // Reload on grant entry and whenever the master is working.
    assign wd_load = (!in_grant && ((state_d == stGrant0) ||
                                    (state_d == stGrant1))) ||
                     (in_grant && I2C_Busy_i);
    assign wd_en   = in_grant && !I2C_Busy_i;

    grant_watchdog u_wd (
        .Clk_i     (Clk_i),
        .Reset_n_i (Reset_n_i),
        .load_i    (wd_load),
        .en_i      (wd_en),
        .preset_i  (ParamGrantTimeout_i),
        .zero_o    (wd_zero)
    );

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q   <= stIdle;
            last_q    <= 1'b1;
            blocked_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            blocked_q <= blocked_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        blocked_d = blocked_q & {Req1_i, Req0_i};
        timeout_d = 1'b0;
        unique case (state_q)
            stIdle: begin
                if (&eff_req) begin
                    state_d = last_q ? stGrant0 : stGrant1;
                end else if (eff_req[0]) begin
                    state_d = stGrant0;
                end else if (eff_req[1]) begin
                    state_d = stGrant1;
                end
            end
            stGrant0, stGrant1: begin
                if (!cur_req && !I2C_Busy_i) begin
                    state_d = stRelease;
                    last_d  = cur_idx;
                end else if (expire) begin
                    state_d            = stRelease;
                    last_d             = cur_idx;
                    timeout_d          = 1'b1;
                    blocked_d[cur_idx] = 1'b1;
                end
            end
            stRelease: state_d = stIdle;
        endcase
    end

    always_comb begin
        Grant0_o            = 1'b0;
        Grant1_o            = 1'b0;
        Busy0_o             = 1'b1;
        Busy1_o             = 1'b1;
        Error0_o            = 1'b0;
        Error1_o            = 1'b0;
        Data0_o             = '0;
        Data1_o             = '0;
        I2C_ReceiveSend_n_o = 1'b0;
        I2C_ReadCount_o     = '0;
        I2C_StartProcess_o  = 1'b0;
        I2C_FIFOReadNext_o  = 1'b0;
        I2C_FIFOWrite_o     = 1'b0;
        I2C_Data_o          = '0;
        unique case (state_q)
            stGrant0: begin
                Grant0_o            = 1'b1;
                Busy0_o             = I2C_Busy_i;
                Error0_o            = I2C_Error_i;
                Data0_o             = I2C_Data_i;
                I2C_ReceiveSend_n_o = ReceiveSend_n0_i;
                I2C_ReadCount_o     = ReadCount0_i;
                I2C_StartProcess_o  = StartProcess0_i & Req0_i;
                I2C_FIFOReadNext_o  = FIFOReadNext0_i;
                I2C_FIFOWrite_o     = FIFOWrite0_i & Req0_i;
                I2C_Data_o          = Data0_i;
            end
            stGrant1: begin
                Grant1_o            = 1'b1;
                Busy1_o             = I2C_Busy_i;
                Error1_o            = I2C_Error_i;
                Data1_o             = I2C_Data_i;
                I2C_ReceiveSend_n_o = ReceiveSend_n1_i;
                I2C_ReadCount_o     = ReadCount1_i;
                I2C_StartProcess_o  = StartProcess1_i & Req1_i;
                I2C_FIFOReadNext_o  = FIFOReadNext1_i;
                I2C_FIFOWrite_o     = FIFOWrite1_i & Req1_i;
                I2C_Data_o          = Data1_i;
            end
            stIdle, stRelease: begin
            end
        endcase
    end

    assign Timeout_o = timeout_q;

endmodule
